timer_arbiter: RTL and testbench
================================

Name: timer_arbiter

Overview:
- Shares one 8-bit up-counter between NREQ requesters that each need a timed interval of a programmable length.
- A round-robin arbiter grants the counter to one requester at a time through a valid/ready handshake. The counter runs the requested length, then the block returns a one-cycle done pulse to the owner.
- Sits between the requesting blocks and the shared counting resource; it is the only sequencer of that resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 8, counter and length width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request; once raised, held until accepted.
- req_len  input  NREQ*CW  per-requester length; slice i is [i*CW +: CW]; sampled on acceptance.
- req_ready  output  NREQ  one-hot grant; accepts requester i when req_valid[i] & req_ready[i].
- done  output  NREQ  one-hot, one-cycle completion pulse to the owning requester.
- busy  output  1  high in RUN and DONE.
- owner  output  clog2(NREQ)  index of the current or last granted requester.
- cnt  output  CW  current counter value.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - state=IDLE, cnt=0, len_q=0, owner=0.
  - rr_ptr=NREQ-1, so requester 0 has top priority first.
  - req_ready=0, done=0, busy=0.
- States IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational: one-hot at the first requester with req_valid=1, searching from rr_ptr+1 upward with wrap.
  - req_ready is all-zero when no request is valid.
  - On the accepting edge: len_q<=req_len[sel], owner<=sel, rr_ptr<=sel, cnt<=0, state<=RUN.
- RUN:
  - req_ready=0.
  - Each edge: if cnt==len_q, state<=DONE; else cnt<=cnt+1.
  - cnt never wraps, since len_q<=2^CW-1. It holds at len_q into DONE.
- DONE:
  - done[owner]=1 for exactly this one cycle; req_ready=0.
  - Next edge: state<=IDLE, cnt<=0.
- Latency: accept in cycle c0 → RUN occupies c1..c1+len → done pulse in cycle c1+len+1 → IDLE in c1+len+2, which can accept in that same cycle.
  - len=0 gives done 2 cycles after accept.
  - len=255 gives done 257 cycles after accept.
- Fairness: the requester just served has the lowest priority at the next arbitration. With all requesters continuously valid, grants cycle 0,1,2,3,0,…
- Requests raised during RUN/DONE wait; they are not lost because valid is held.
- req_valid dropped before acceptance is a protocol violation. Under SIMULATION an assertion fires.
- req_len changes while waiting are allowed; only the value at acceptance counts.
- Reset mid-RUN: immediate return to reset values; no done pulse is produced for the aborted interval.

Optional Feature:
- Macro TIMER_ARBITER_ABORT_EN.
- Defined: adds two ports.
  - abort  input  1: in RUN or DONE, the next edge forces state<=IDLE and cnt<=0, and done is suppressed.
  - aborted  output  NREQ: registered, one-hot; aborted[owner] pulses for 1 cycle after the abort edge.
  - rr_ptr still advances past the aborted owner.
  - abort in IDLE is ignored.
- Undefined: no abort/aborted ports; behaviour exactly as above.

Decomposition:
- Package timer_arbiter_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default CW and NREQ constants;
  - an index-width function used for owner/rr_ptr.
- Sub-module rr_arbiter: combinational round-robin picker. Inputs req[NREQ], ptr; outputs onehot grant, index, any.
- timer_arbiter holds the FSM, counter and registers.

Test Plan:
- Reset mid-RUN: grant req0 with len=10, assert rst at cnt=4 → outputs immediately at reset values, no done[0]. After release, req0 is granted first again.
- Single request: req_valid[2]=1, len=5 after reset → req_ready=4'b0100 in the same cycle, cnt 0..5, done=4'b0100 exactly 7 cycles after accept, busy high for 7 cycles.
- Boundaries: len=0 → done 2 cycles after accept. len=255 → cnt reaches 255 without wrap, done 257 cycles after accept, cnt=0 next.
- Round-robin: all four valid continuously, len=3 each → grant order 0,1,2,3,0. Each done 5 cycles after its accept; consecutive grants 6 cycles apart.
- Arrival during RUN: req1 raised while req3 runs with len=8 → req1 is not readied until the IDLE cycle after done[3], then accepted in that same cycle.
- TIMER_ARBITER_ABORT_EN: grant req1 with len=20, abort at cnt=7 → cnt=0 and IDLE next cycle, aborted=4'b0010 for 1 cycle, no done[1]. Pending req2 is granted in the following cycle.

Source files
------------

// File: rtl/timer_arbiter_pkg.sv
// Shared types and constants for the timer_arbiter block.
//   state_t  : FSM encoding (IDLE / RUN / DONE)
//   DEF_NREQ : default number of requesters
//   DEF_CW   : default counter / length width
//   idx_w()  : width of a requester index (owner, rr_ptr), never below 1
package timer_arbiter_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_CW   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// Requester-side bundle of the timer_arbiter.
//   req_valid : per-requester request, held until accepted
//   req_len   : per-requester interval length, slice i is [i*CW +: CW]
//   req_ready : one-hot grant
//   done      : one-hot, one-cycle completion pulse
//   busy      : counter is owned (RUN or DONE)
//   owner     : index of the current or last granted requester
//   cnt       : current counter value
// master = requesters, slave = arbiter.
interface timer_arbiter_if
    import timer_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*CW-1:0]     req_len;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        done;
    logic                   busy;
    logic [idx_w(NREQ)-1:0] owner;
    logic [CW-1:0]          cnt;

    modport master (
        output req_valid, req_len,
        input  req_ready, done, busy, owner, cnt
    );

    modport slave (
        input  req_valid, req_len,
        output req_ready, done, busy, owner, cnt
    );
endinterface

// File: rtl/timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index of the last served requester (lowest priority)
//   grant : one-hot pick, searching upward from ptr+1 with wrap
//   idx   : index of the picked requester
//   any   : at least one request present
module timer_arbiter_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        // i = NREQ lands back on ptr itself, so it is considered last.
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end
endmodule

// File: rtl/timer_arbiter.sv
// Shares one up-counter between NREQ requesters. A round-robin pick grants
// the counter in IDLE; the counter runs 0..len, then the owner receives a
// one-cycle done pulse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : timer_arbiter_if slave (request/grant/done/status)
//   abort    : (TIMER_ARBITER_ABORT_EN only) cancel the running interval
//   aborted  : (TIMER_ARBITER_ABORT_EN only) one-hot pulse to the cancelled owner
// Optional feature macro: TIMER_ARBITER_ABORT_EN.
//
// state | meaning
// IDLE  | counter free, req_ready shows the round-robin pick
// RUN   | counter advancing toward len_q
// DONE  | done[owner] high for this one cycle
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW
) (
    input  logic            clk,
    input  logic            rst,
`ifdef TIMER_ARBITER_ABORT_EN
    input  logic            abort,
    output logic [NREQ-1:0] aborted,
`endif
    timer_arbiter_if.slave  bus
);
    localparam int IW = idx_w(NREQ);

    state_t          state;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   len_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] done_q;
    logic            busy_q;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [CW-1:0]   len_sel;
    logic [NREQ-1:0] owner_oh;

    timer_arbiter_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) len_sel = bus.req_len[i*CW +: CW];
        end
    end

    assign owner_oh = NREQ'(1) << owner_q;

    // Ready is only offered while idle and out of reset.
    assign bus.req_ready = (state == IDLE && !rst) ? pick_grant : '0;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.cnt       = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            owner_q <= '0;
            rr_ptr  <= IW'(NREQ - 1);
            done_q  <= '0;
            busy_q  <= 1'b0;
`ifdef TIMER_ARBITER_ABORT_EN
            aborted <= '0;
`endif
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        len_q   <= len_sel;
                        owner_q <= pick_idx;
                        rr_ptr  <= pick_idx;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_q == len_q) begin
                        state  <= DONE;
                        done_q <= owner_oh;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    cnt_q  <= '0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cnt_q  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
`ifdef TIMER_ARBITER_ABORT_EN
            // Placed after the case so it overrides any RUN/DONE update.
            aborted <= '0;
            if (abort && state != IDLE) begin
                state   <= IDLE;
                cnt_q   <= '0;
                done_q  <= '0;
                busy_q  <= 1'b0;
                aborted <= owner_oh;
            end
`endif
        end
    end

`ifdef SIMULATION
    // A requester that was waiting last cycle must still be requesting.
    logic [NREQ-1:0] waiting_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) waiting_q <= '0;
        else     waiting_q <= bus.req_valid & ~bus.req_ready;
    end

    always @(posedge clk) begin
        if (!rst) assert ((waiting_q & ~bus.req_valid) == '0);
    end
`endif
endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;
    localparam int NREQ = 4;
    localparam int CW   = 8;

    typedef struct {
        int              idx;
        int              len;
        logic [NREQ-1:0] oh;
        int              lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef TIMER_ARBITER_ABORT_EN
    logic            abort = 1'b0;
    logic [NREQ-1:0] aborted;
`endif

    timer_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

    timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef TIMER_ARBITER_ABORT_EN
        .abort   (abort),
        .aborted (aborted),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Scoreboard: expected grants queued by the stimulus, consumed by the monitor.
    vec_t            exp_q[$];
    vec_t            act;
    bit              act_on = 1'b0;
    int              act_acc = 0;
    int              acc_log[$];
    bit              mon_en = 1'b0;
    int              cyc = 0;
    int              d;
    bit              fin;
    logic [NREQ-1:0] hs;
    logic [NREQ-1:0] hs_last = '0;
    logic            e_busy;
    logic [CW-1:0]   e_cnt;
    logic [NREQ-1:0] e_done;
    int              pend_n[NREQ];

    always @(negedge clk) begin
        cyc     = cyc + 1;
        hs      = bus.req_valid & bus.req_ready;
        hs_last = hs;
        if (mon_en) begin
            fin    = 1'b0;
            e_busy = 1'b0;
            e_cnt  = '0;
            e_done = '0;
            if (act_on) begin
                d      = cyc - act_acc;
                e_busy = 1'b1;
                if (d < act.lat) begin
                    e_cnt = CW'(d - 1);
                end else begin
                    e_cnt  = CW'(act.len);
                    e_done = act.oh;
                    fin    = 1'b1;
                end
                chk("ready_while_busy", 32'(bus.req_ready), 32'(0));
                chk("owner", 32'(bus.owner), 32'(act.idx));
            end
            chk("busy_cnt_done", 32'({bus.busy, bus.cnt, bus.done}), 32'({e_busy, e_cnt, e_done}));
            if (!act_on) begin
                chk("ready_only_valid", 32'(bus.req_ready & ~bus.req_valid), 32'(0));
                if (bus.req_valid != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_request", 32'(bus.req_valid), 32'(0));
                    end else begin
                        chk("grant", 32'(hs), 32'(exp_q[0].oh));
                        if (hs != '0) begin
                            act     = exp_q.pop_front();
                            act_on  = 1'b1;
                            act_acc = cyc;
                            acc_log.push_back(cyc);
                        end
                    end
                end
            end
            if (fin) act_on = 1'b0;
        end
    end

    // One clock; then retire requests that were accepted on that edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_last[i]) begin
                pend_n[i]--;
                if (pend_n[i] <= 0) bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic raise(input int idx, input int len, input int n);
        bus.req_len[idx*CW +: CW] = CW'(len);
        pend_n[idx]               = n;
        bus.req_valid[idx]        = 1'b1;
    endtask

    task automatic expect_grant(input int idx, input int len, input int lat);
        vec_t v;
        v.idx = idx;
        v.len = len;
        v.oh  = NREQ'(1) << idx;
        v.lat = lat;
        exp_q.push_back(v);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || act_on || bus.req_valid != '0) && k < budget) begin
            step();
            k++;
        end
        chk(nm, 32'(k < budget), 32'(1));
    endtask

    task automatic do_reset();
        mon_en        = 1'b0;
        rst           = 1'b1;
        bus.req_valid = '0;
        for (int i = 0; i < NREQ; i++) pend_n[i] = 0;
        act_on = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    vec_t vecs[6];
    int   k;

    initial begin
        bus.req_valid = '0;
        bus.req_len   = '0;

        vecs[0] = '{2, 5,   4'b0100, 7};
        vecs[1] = '{0, 0,   4'b0001, 2};
        vecs[2] = '{3, 1,   4'b1000, 3};
        vecs[3] = '{1, 7,   4'b0010, 9};
        vecs[4] = '{2, 255, 4'b0100, 257};
        vecs[5] = '{0, 2,   4'b0001, 4};

        do_reset();
        chk("reset_outputs",
            32'({bus.busy, bus.cnt, bus.done, bus.req_ready, bus.owner}), 32'(0));

        // Single requests, one at a time.
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(vecs[v]);
            raise(vecs[v].idx, vecs[v].len, 1);
            wait_idle(400, "vec_idle");
        end

        // Round-robin with all four requesters held valid.
        do_reset();
        acc_log.delete();
        expect_grant(0, 3, 5);
        expect_grant(1, 3, 5);
        expect_grant(2, 3, 5);
        expect_grant(3, 3, 5);
        expect_grant(0, 3, 5);
        raise(0, 3, 2);
        raise(1, 3, 1);
        raise(2, 3, 1);
        raise(3, 3, 1);
        wait_idle(100, "rr_idle");
        chk("rr_grants", 32'(acc_log.size()), 32'(5));
        for (int j = 0; j + 1 < acc_log.size(); j++)
            chk("rr_spacing", 32'(acc_log[j+1] - acc_log[j]), 32'(6));

        // Request arriving while another interval runs.
        acc_log.delete();
        expect_grant(3, 8, 10);
        raise(3, 8, 1);
        repeat (3) step();
        expect_grant(1, 4, 6);
        raise(1, 4, 1);
        wait_idle(100, "arrival_idle");
        chk("arrival_grants", 32'(acc_log.size()), 32'(2));
        if (acc_log.size() == 2)
            chk("arrival_gap", 32'(acc_log[1] - acc_log[0]), 32'(11));

        // Reset in the middle of an interval.
        do_reset();
        mon_en = 1'b0;
        raise(0, 10, 1);
        k = 0;
        while (bus.cnt != 8'd4 && k < 30) begin
            step();
            k++;
        end
        chk("rst_mid_cnt", 32'(bus.cnt), 32'(4));
        rst = 1'b1;
        #1;
        chk("rst_async",
            32'({bus.busy, bus.cnt, bus.done, bus.req_ready, bus.owner}), 32'(0));
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", 32'(bus.done), 32'(0));
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        act_on = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        expect_grant(0, 2, 4);
        expect_grant(1, 2, 4);
        raise(0, 2, 1);
        raise(1, 2, 1);
        wait_idle(100, "rst_after_idle");

`ifdef TIMER_ARBITER_ABORT_EN
        do_reset();
        mon_en = 1'b0;
        raise(1, 20, 1);
        raise(2, 3, 1);
        k = 0;
        while (bus.cnt != 8'd7 && k < 40) begin
            step();
            k++;
        end
        chk("abort_pre_cnt", 32'({bus.owner, bus.cnt}), 32'({2'd1, 8'd7}));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", 32'({bus.busy, bus.cnt, bus.done}), 32'(0));
        chk("aborted_pulse", 32'(aborted), 32'(4'b0010));
        chk("abort_next_ready", 32'(bus.req_ready), 32'(4'b0100));
        step();
        chk("aborted_clear", 32'(aborted), 32'(0));
        chk("abort_next_owner", 32'({bus.busy, bus.owner}), 32'({1'b1, 2'd2}));
        repeat (8) begin
            step();
            chk("abort_no_done1", 32'(bus.done[1]), 32'(0));
        end
        chk("abort_req2_finished", 32'(bus.busy), 32'(0));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_in_idle", 32'({bus.busy, aborted}), 32'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
